// File: rtl/crypto_stream_tx.sv
// Keyed XOR-rotate stream cipher feeding a ciphertext FIFO that is drained by an 8N1 UART
// transmitter. Optional chaining mixes the previous ciphertext into each new word.
module crypto_stream_tx #(
  parameter int unsigned     DBITS        = 8,
  parameter int unsigned     DEPTH        = 8,
  parameter int unsigned     ROT          = 1,
  parameter int unsigned     CLKS_PER_BIT = 5208,
  parameter logic [DBITS-1:0] IV          = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DBITS-1:0]         in_data,
  input  logic [DBITS-1:0]         key,
  input  logic                     mode,
  input  logic                     chain_clr,
  input  logic                     select,
  output logic                     in_ready,
  output logic                     tx,
  output logic                     tx_done_tick,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     drop_err,
  output logic [DBITS-1:0]         led_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [BW-1:0] BaudLast  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IdxLast   = IW'(DBITS - 1);
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [DBITS-1:0]   shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               tick_q, tick_d;

  logic [DBITS-1:0]   mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [DBITS-1:0]   chain_q, chain_d;
  logic [DBITS-1:0]   last_plain_q, last_plain_d;
  logic [DBITS-1:0]   last_cipher_q, last_cipher_d;
  logic               drop_q, drop_d;

  logic               full, empty, push, pop, baud_last;
  logic [DBITS-1:0]   mix;
  logic [2*DBITS-1:0] mix_dbl;
  logic [DBITS-1:0]   cipher;

  assign full  = (count_q == FullCount);
  assign empty = (count_q == '0);
  assign push  = in_valid && !full;
  assign pop   = (state_q == StIdle) && !empty;

  // Rotate-left: the upper half of {x, x} << ROT wraps the high bits around.
  always_comb begin
    mix     = in_data ^ key ^ (mode ? chain_q : '0);
    mix_dbl = {mix, mix} << ROT;
    cipher  = mix_dbl[2*DBITS-1:DBITS];
  end

  always_comb begin
    wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d      = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d       = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    last_plain_d  = push ? in_data : last_plain_q;
    last_cipher_d = push ? cipher : last_cipher_q;
    // A clear wins over the update from a word accepted in the same cycle.
    if (chain_clr) begin
      chain_d = IV;
    end else if (push) begin
      chain_d = cipher;
    end else begin
      chain_d = chain_q;
    end
    if (chain_clr) begin
      drop_d = 1'b0;
    end else if (in_valid && full) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    tick_d    = 1'b0;
    baud_last = (baud_q == BaudLast);
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d  = '0;
          tick_d  = 1'b1;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset; emptying the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cipher;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      baud_q        <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      tx_q          <= 1'b1;
      tick_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      chain_q       <= IV;
      last_plain_q  <= '0;
      last_cipher_q <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      tx_q          <= tx_d;
      tick_q        <= tick_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      chain_q       <= chain_d;
      last_plain_q  <= last_plain_d;
      last_cipher_q <= last_cipher_d;
      drop_q        <= drop_d;
    end
  end

  assign in_ready     = !full;
  assign tx           = tx_q;
  assign tx_done_tick = tick_q;
  assign busy         = !empty || (state_q != StIdle);
  assign fifo_count   = count_q;
  assign drop_err     = drop_q;
  assign led_out      = select ? last_cipher_q : last_plain_q;

endmodule

// File: tb/tb_crypto_stream_tx.sv
// Bench for crypto_stream_tx: vector table plus corner-case sequences, with a UART monitor
// that decodes every frame and checks it against a queue of expected ciphertexts.
module tb_crypto_stream_tx;

  localparam int unsigned DBITS = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned ROT   = 1;
  localparam int unsigned CPB   = 4;
  localparam int unsigned FRAME = (DBITS + 2) * CPB;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [DBITS-1:0] in_data;
  logic [DBITS-1:0] key;
  logic             mode;
  logic             chain_clr;
  logic             select;
  logic             in_ready;
  logic             tx;
  logic             tx_done_tick;
  logic             busy;
  logic [3:0]       fifo_count;
  logic             drop_err;
  logic [DBITS-1:0] led_out;

  crypto_stream_tx #(
    .DBITS       (DBITS),
    .DEPTH       (DEPTH),
    .ROT         (ROT),
    .CLKS_PER_BIT(CPB),
    .IV          (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .key         (key),
    .mode        (mode),
    .chain_clr   (chain_clr),
    .select      (select),
    .in_ready    (in_ready),
    .tx          (tx),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .drop_err    (drop_err),
    .led_out     (led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] m_chain;
  int frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_c(input logic [7:0] p, input logic [7:0] k,
                                         input logic m, input logic [7:0] ch);
    logic [7:0] x;
    x = p ^ k ^ (m ? ch : 8'h00);
    return {x[6:0], x[7]};
  endfunction

  // UART monitor: cnt 0 is the first low sample; bit j spans cnt 4j..4j+3, sampled at 4j+1.
  logic       mon_busy = 1'b0;
  int         mon_cnt  = 0;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    if (rst) begin
      mon_busy = 1'b0;
      mon_cnt  = 0;
    end else begin
      if (!mon_busy && tx == 1'b0) begin
        mon_busy = 1'b1;
        mon_cnt  = 0;
      end else if (mon_busy) begin
        mon_cnt++;
      end
      if (mon_busy) begin
        if (mon_cnt == 1) check("start_bit", tx, 1'b0);
        if (mon_cnt >= 5 && mon_cnt <= 33 && (mon_cnt - 1) % CPB == 0)
          rx_byte[(mon_cnt - 5) / CPB] = tx;
        if (mon_cnt == 37) begin
          check("stop_bit", tx, 1'b1);
          frames++;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            check("frame_data", rx_byte, sb.pop_front());
          end
        end
      end
      check("tick_pos", tx_done_tick, (mon_busy && mon_cnt == FRAME - 1));
      if (mon_busy && mon_cnt == FRAME - 1) mon_busy = 1'b0;
    end
  end

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((busy || mon_busy || sb.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= max_cycles), 0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    chain_clr = 1'b1;
    @(negedge clk);
    chain_clr = 1'b0;
    m_chain   = 8'h00;
  endtask

  // Offer one word for one edge; expected ciphertext is queued only if it is accepted.
  task automatic offer(input logic [7:0] d);
    logic [7:0] c;
    in_data  = d;
    in_valid = 1'b1;
    if (in_ready) begin
      c = model_c(d, key, mode, m_chain);
      sb.push_back(c);
      m_chain = c;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] plain;
    logic [7:0] key;
    logic       mode;
    logic       clr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    int f0;
    int n;
    vecs[0] = '{8'h3C, 8'hA5, 1'b0, 1'b0, 8'h33};
    vecs[1] = '{8'h3C, 8'hA5, 1'b1, 1'b1, 8'h33};
    vecs[2] = '{8'h3C, 8'hA5, 1'b1, 1'b0, 8'h55};
    vecs[3] = '{8'h3C, 8'hA5, 1'b1, 1'b1, 8'h33};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{8'hFF, 8'h0F, 1'b0, 1'b0, 8'hE1};
    vecs[6] = '{8'h80, 8'h00, 1'b0, 1'b0, 8'h01};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h4E};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; key = '0; mode = 1'b0;
    chain_clr = 1'b0; select = 1'b0; m_chain = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_tick", tx_done_tick, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_err, 1'b0);
    check("rst_led", led_out, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Table: cipher value, LED mux, single-word latency.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr) pulse_clr();
      key  = vecs[i].key;
      mode = vecs[i].mode;
      check("vec_in_ready", in_ready, 1'b1);
      sb.push_back(vecs[i].exp);
      m_chain  = vecs[i].exp;
      in_data  = vecs[i].plain;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("vec_count_1", fifo_count, 1);
      check("vec_tx_still_idle", tx, 1'b1);
      select = 1'b0;
      #1 check("vec_led_plain", led_out, vecs[i].plain);
      select = 1'b1;
      #1 check("vec_led_cipher", led_out, vecs[i].exp);
      select = 1'b0;
      @(negedge clk);
      check("vec_count_popped", fifo_count, 0);
      check("vec_busy", busy, 1'b1);
      @(negedge clk);
      check("vec_tx_start", tx, 1'b0);
      wait_idle(FRAME + 20);
      check("vec_busy_low", busy, 1'b0);
    end

    // Overflow: hold in_valid for 12 edges, chained mode, across pointer wrap.
    mode = 1'b1; key = 8'h5A;
    pulse_clr();
    f0  = frames;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) acc++;
      offer(8'(i * 37 + 11));
    end
    in_valid = 1'b0;
    check("ovf_accepted", acc, 9);
    check("ovf_count_full", fifo_count, 8);
    check("ovf_in_ready_low", in_ready, 1'b0);
    check("ovf_drop_err", drop_err, 1'b1);
    wait_idle(9 * (FRAME + 2) + 20);
    check("ovf_frames", frames - f0, 9);

    // Simultaneous push and pop with three words queued.
    mode = 1'b0; key = 8'hC3;
    for (int i = 0; i < 4; i++) offer(8'(8'h40 + i));
    in_valid = 1'b0;
    check("pp_count_before", fifo_count, 3);
    n = 0;
    while (!tx_done_tick && n < FRAME + 10) begin
      @(negedge clk);
      n++;
    end
    check("pp_tick_timeout", (n >= FRAME + 10), 0);
    check("pp_count_at_pop", fifo_count, 3);
    offer(8'h99);
    in_valid = 1'b0;
    check("pp_count_after", fifo_count, 3);
    wait_idle(5 * (FRAME + 2) + 20);

    // Reset during DATA bit 4 with another word still queued.
    check("pre_rst_drop", drop_err, 1'b1);
    mode = 1'b0; key = 8'h11;
    offer(8'hA0);
    offer(8'hA1);
    in_valid = 1'b0;
    check("mid_count", fifo_count, 1);
    repeat (21) @(negedge clk);
    check("mid_in_data_frame", busy, 1'b1);
    f0  = frames;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_drop", drop_err, 1'b0);
    check("mid_rst_led", led_out, 8'h00);
    rst = 1'b0;
    sb.delete();
    m_chain = 8'h00;
    repeat (FRAME) @(negedge clk);
    check("mid_no_frame", frames - f0, 0);
    mode = 1'b1; key = 8'h5A;
    offer(8'h3C);
    in_valid = 1'b0;
    wait_idle(FRAME + 20);
    check("mid_post_frame", frames - f0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
